// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge detector: mode encodings and a
// constant-evaluable ceil(log2) helper.
package edge_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_channel.sv
// One detector channel: input synchroniser, delayed copy, mode-selected edge
// detect and the sticky pending/overflow state.
module edge_channel
  import edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x_i,
  input  logic       ready_i,
  input  logic [1:0] mode_i,
  input  logic       clr_i,
  output logic       y_o,
  output logic       ovf_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   y_q, y_d;
  logic                   ovf_q, ovf_d;
  logic                   s, rise, fall, det;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Sync chain and prev keep loading during warm-up so a level held through
  // reset is already settled when detection is enabled.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], x_i};
    prev_d = s;
  end

  always_comb begin
    det = 1'b0;
    unique case (mode_i)
      EDGE_OFF:  det = 1'b0;
      EDGE_RISE: det = rise;
      EDGE_FALL: det = fall;
      EDGE_BOTH: det = rise | fall;
      default:   det = 1'b0;
    endcase
    det = det & ready_i;
  end

  // A clear always drops overflow; a clear racing a new edge keeps the channel
  // pending, since the fresh event replaces the one being acknowledged.
  always_comb begin
    y_d   = det | (y_q & ~clr_i);
    ovf_d = ovf_q;
    if (clr_i) begin
      ovf_d = 1'b0;
    end else if (det && y_q) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      y_q    <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      y_q    <= y_d;
      ovf_q  <= ovf_d;
    end
  end

  assign y_o   = y_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel sticky edge detector with per-channel mode, clear and overflow,
// a post-reset warm-up gate and a combined interrupt.
module multi_edge_detector
  import edge_pkg::*;
#(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   x,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   y,
  output logic [CHANNELS-1:0]   ovf,
  output logic                  irq,
  output logic                  ready
);

  localparam int unsigned CntW = clog2(SYNC_STAGES + 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;

  // Counter stops once ready is set; ready lands on edge SYNC_STAGES+1.
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (!ready_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(SYNC_STAGES)) begin
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_channel #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .x_i    (x[i]),
      .ready_i(ready_q),
      .mode_i (mode[2*i+:2]),
      .clr_i  (clr[i]),
      .y_o    (y[i]),
      .ovf_o  (ovf[i])
    );
  end

  assign ready = ready_q;
  assign irq   = |y;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed self-checking bench for multi_edge_detector (8 channels, 2 sync stages).
module tb_multi_edge_detector;

  logic        clk;
  logic        rst_n;
  logic [7:0]  x;
  logic [15:0] mode;
  logic [7:0]  clr;
  logic [7:0]  y;
  logic [7:0]  ovf;
  logic        irq;
  logic        ready;

  int n_total;
  int n_pass;

  multi_edge_detector #(
    .CHANNELS   (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .x    (x),
    .mode (mode),
    .clr  (clr),
    .y    (y),
    .ovf  (ovf),
    .irq  (irq),
    .ready(ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    x     = 8'hFF;
    mode  = 16'h5555;
    clr   = 8'h00;
    tick(2);
    n_total++;
    if ({ready, irq, y, ovf} !== 18'h0)
      $display("FAIL reset_state got ready=%b irq=%b y=%h ovf=%h exp all 0", ready, irq, y, ovf);
    else n_pass++;
    rst_n = 1'b1;
    tick(2);
    n_total++;
    if (ready !== 1'b0) $display("FAIL warmup_edge2 got ready=%b exp 0", ready);
    else n_pass++;
    tick(1);
    n_total++;
    if (ready !== 1'b1) $display("FAIL warmup_edge3 got ready=%b exp 1", ready);
    else n_pass++;
    for (int c = 0; c < 20; c++) begin
      n_total++;
      if ({irq, y, ovf} !== 17'h0)
        $display("FAIL no_spurious c=%0d got irq=%b y=%h ovf=%h exp 0", c, irq, y, ovf);
      else n_pass++;
      tick(1);
    end
    // Falling edges in rising mode must not detect.
    x = 8'h00;
    tick(4);
    n_total++;
    if (y !== 8'h00) $display("FAIL fall_in_rise_mode got y=%h exp 00", y);
    else n_pass++;
  endtask

  task automatic test_rising();
    x[0] = 1'b1;
    tick(2);
    n_total++;
    if (y !== 8'h00) $display("FAIL rise_early got y=%h exp 00", y);
    else n_pass++;
    tick(1);
    n_total++;
    if (y !== 8'h01 || irq !== 1'b1) $display("FAIL rise_lat got y=%h irq=%b exp 01 1", y, irq);
    else n_pass++;
    x[0] = 1'b0;
    tick(4);
    n_total++;
    if (y !== 8'h01 || ovf !== 8'h00) $display("FAIL rise_hold got y=%h ovf=%h exp 01 00", y, ovf);
    else n_pass++;
    clr = 8'h01;
    tick(1);
    clr = 8'h00;
    n_total++;
    if (y !== 8'h00 || irq !== 1'b0) $display("FAIL rise_clr got y=%h irq=%b exp 00 0", y, irq);
    else n_pass++;
  endtask

  task automatic test_modes();
    mode[7:6]   = 2'b10;
    mode[9:8]   = 2'b11;
    mode[11:10] = 2'b00;
    tick(2);
    x[5:3] = 3'b111;
    tick(3);
    n_total++;
    if (y !== 8'h10) $display("FAIL mode_rise got y=%h exp 10", y);
    else n_pass++;
    tick(1);
    x[5:3] = 3'b000;
    tick(2);
    n_total++;
    if (y !== 8'h10) $display("FAIL mode_fall_early got y=%h exp 10", y);
    else n_pass++;
    tick(1);
    // ch3 fires on the fall; ch4 (both) fires again while pending -> overflow.
    n_total++;
    if (y !== 8'h18 || ovf !== 8'h10) $display("FAIL mode_fall got y=%h ovf=%h exp 18 10", y, ovf);
    else n_pass++;
    clr = 8'hFF;
    tick(1);
    clr = 8'h00;
    tick(4);
    n_total++;
    if (y !== 8'h00 || ovf !== 8'h00) $display("FAIL mode_clr got y=%h ovf=%h exp 00 00", y, ovf);
    else n_pass++;
  endtask

  task automatic test_overflow();
    x[1] = 1'b1;
    tick(3);
    n_total++;
    if (y !== 8'h02 || ovf !== 8'h00) $display("FAIL ovf_first got y=%h ovf=%h exp 02 00", y, ovf);
    else n_pass++;
    x[1] = 1'b0;
    tick(3);
    x[1] = 1'b1;
    tick(3);
    n_total++;
    if (y !== 8'h02 || ovf !== 8'h02) $display("FAIL ovf_set got y=%h ovf=%h exp 02 02", y, ovf);
    else n_pass++;
    clr[1] = 1'b1;
    tick(1);
    clr[1] = 1'b0;
    n_total++;
    if (y !== 8'h00 || ovf !== 8'h00) $display("FAIL ovf_clr got y=%h ovf=%h exp 00 00", y, ovf);
    else n_pass++;
    x[1] = 1'b0;
    tick(3);
  endtask

  task automatic test_back_to_back();
    x[2] = 1'b1;
    tick(3);
    n_total++;
    if (y !== 8'h04) $display("FAIL b2b_first got y=%h exp 04", y);
    else n_pass++;
    x[2] = 1'b0;
    tick(3);
    x[2] = 1'b1;
    tick(2);
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    n_total++;
    if (y !== 8'h04 || ovf !== 8'h00) $display("FAIL b2b_clr_det got y=%h ovf=%h exp 04 00", y, ovf);
    else n_pass++;
    clr[2] = 1'b1;
    tick(1);
    clr[2] = 1'b0;
    n_total++;
    if (y !== 8'h00) $display("FAIL b2b_clr got y=%h exp 00", y);
    else n_pass++;
    x[2] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid();
    mode = 16'h5555;
    tick(1);
    x = 8'h0F;
    tick(3);
    x[0] = 1'b0;
    tick(3);
    x[0] = 1'b1;
    tick(3);
    n_total++;
    if (y !== 8'h0F || ovf !== 8'h01) $display("FAIL mid_setup got y=%h ovf=%h exp 0F 01", y, ovf);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({ready, irq, y, ovf} !== 18'h0)
      $display("FAIL mid_async got ready=%b irq=%b y=%h ovf=%h exp all 0", ready, irq, y, ovf);
    else n_pass++;
    #1;
    rst_n = 1'b1;
    tick(2);
    n_total++;
    if (ready !== 1'b0) $display("FAIL mid_warm2 got ready=%b exp 0", ready);
    else n_pass++;
    tick(1);
    n_total++;
    if (ready !== 1'b1) $display("FAIL mid_warm3 got ready=%b exp 1", ready);
    else n_pass++;
    tick(5);
    n_total++;
    if (y !== 8'h00 || ovf !== 8'h00) $display("FAIL mid_quiet got y=%h ovf=%h exp 00 00", y, ovf);
    else n_pass++;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    x       = 8'h00;
    mode    = 16'h0000;
    clr     = 8'h00;
    test_reset();
    test_rising();
    test_modes();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
# multi_edge_detector

Parametrised, multi-channel successor to the single-bit rising-edge latch. Each channel synchronises an asynchronous input, detects rising, falling or both edges per a per-channel mode, and holds a sticky pending flag until it is explicitly cleared. The block also records overflow on a pending channel and raises a combined interrupt. It sits between external pins or peripheral strobes and the CPU's I/O/interrupt register bank.

## Interface
- `CHANNELS`, default 8: number of independent input channels (1..32).
- `SYNC_STAGES`, default 2: synchroniser flops per channel (≥2).
- `clk`, in, 1: single system clock; all state is updated on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `x`, in, CHANNELS: raw asynchronous inputs.
- `mode`, in, 2*CHANNELS: per-channel mode, channel i at bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- `clr`, in, CHANNELS: per-channel clear strobe, synchronous, level-sampled.
- `y`, out, CHANNELS: sticky pending flags (registered).
- `ovf`, out, CHANNELS: sticky overflow flags (registered).
- `irq`, out, 1: OR of all `y` bits (combinational from registers).
- `ready`, out, 1: warm-up finished; detection is enabled (registered).

## Operation
- Per channel, `x[i]` passes through a SYNC_STAGES flop chain. The last stage is `s[i]`, and `prev[i]` is `s[i]` delayed by one clock.
- Raw edges:
  - rise = s & ~prev
  - fall = ~s & prev
  - det = (mode[0] & rise) | (mode[1] & fall) | ... evaluated with `ready` = 1.
- Per-channel FSM (state = `y[i]`):
  - IDLE (y = 0): det → PENDING; otherwise stay in IDLE.
  - PENDING (y = 1): clr & ~det → IDLE. det & ~clr → stay in PENDING and set `ovf[i]`. clr & det → stay in PENDING and clear `ovf[i]`, because the new event replaces the old one. Otherwise stay in PENDING.
- `clr` in IDLE: `y` has no change; `ovf[i]` is cleared.
- `ovf[i]` is cleared only by `clr[i]` (or by reset). A detect in IDLE never sets `ovf`.
- Mode changes take effect on the next clock. Setting mode 00 stops new detections but does not clear `y` or `ovf`.
- Warm-up: a counter of width clog2(SYNC_STAGES+2) counts SYNC_STAGES+1 clocks after `rst_n` deasserts, then sets `ready`. While `ready` = 0, det is forced to 0 and the sync and `prev` flops still load. As a result, an input held high through reset never produces a spurious rising edge.

## Timing
- Reset values: sync chain, `prev`, `y`, `ovf`, the warm-up counter and `ready` are all 0. `irq` is 0.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Warm-up restarts after deassertion.
- `ready` is 1 after rising edge number SYNC_STAGES+1 following deassertion. With SYNC_STAGES = 2, that is after the 3rd edge.
- Detection latency: if `x[i]` changes and is stable before clock edge n, then `y[i]` = 1 after edge n+SYNC_STAGES. With the default of 2, `y` rises after edge n+2, and `irq` rises in the same cycle.
- Clear latency: `clr[i]` sampled high at edge n → `y[i]` = 0 after edge n, unless det is also true at edge n.
- Pulses narrower than one clock period may be missed. That is acceptable.
- The raw edge is a one-cycle event per transition. A held input level never re-triggers detection.

## Structure
- Shared package `edge_pkg`:
  - mode encodings `EDGE_OFF`, `EDGE_RISE`, `EDGE_FALL`, `EDGE_BOTH` (2-bit localparams)
  - a clog2 helper function
- Sub-module `edge_channel`: one channel, containing the synchroniser, `prev`, the det logic and the `y`/`ovf` FSM. Inputs are `ready`, the 2-bit mode and `clr`.
- The top level holds the warm-up counter, the `ready` register, a generate loop over the channels and the `irq` reduction.

## Test plan
- Reset/warm-up: hold `x` = 8'hFF in modes 01 through reset, then release → `ready` rises after the 3rd edge, and `y`, `ovf` and `irq` stay 0 for 20 cycles.
- Rising latency: with `ready` = 1 and mode = 01, drive `x[0]` 0→1 before edge n → `y[0]` = 1 after edge n+2 and `irq` = 1. Drive `x[0]` 1→0 → no change.
- Mode coverage:
  - `x[3]` in mode 10, pulsed 0→1→0 (4 cycles high) → one detection on the fall only.
  - `x[4]` in mode 11 → detected on the rise.
  - `x[5]` in mode 00 → never detected.
- Overflow: set `y[1]`, then a second rising edge on `x[1]` with `clr` = 0 → `ovf[1]` = 1. Then `clr[1]` for one cycle → `y[1]` = 0 and `ovf[1]` = 0.
- Simultaneous clr and edge: `y[2]` = 1, with `clr[2]` asserted in the same cycle that det fires → `y[2]` stays 1 and `ovf[2]` = 0.
- Reset mid-operation: with `y` = 8'h0F and `ovf` = 8'h01, pulse `rst_n` low asynchronously between edges → `y`, `ovf` and `ready` are 0 immediately, and `ready` returns 3 edges after release.
